// File: rtl/adder_accumulator.sv
// Accumulator stage that drives an external ripple adder from registers, holds its
// inputs for a programmable settle window, then captures sum and flags.
module adder_accumulator #(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [31:0] in_data,
   output logic [31:0] adder_a,
   output logic [31:0] adder_b,
   output logic        adder_subtract,
   input  logic [31:0] adder_sum,
   input  logic        adder_carryout,
   input  logic        adder_overflow,
   input  logic        adder_zero,
   output logic [31:0] acc,
   output logic        flag_zero,
   output logic        flag_carry,
   output logic        flag_overflow,
   output logic        sticky_overflow,
   output logic        done
);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_CMP  = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   // Handshake: an operation is accepted on a rising edge where in_valid && in_ready;
   // in_ready is high only in IDLE, and in_op/in_data are sampled only at accept.
   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;
   logic             op_cmp;
   logic             accept;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign adder_a  = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept && (in_op != OP_LOAD)) begin
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (count == '0) begin
               state_next = CAPTURE;
            end
         end
         CAPTURE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc             <= '0;
         adder_b         <= '0;
         adder_subtract  <= 1'b0;
         op_cmp          <= 1'b0;
         count           <= '0;
         flag_zero       <= 1'b0;
         flag_carry      <= 1'b0;
         flag_overflow   <= 1'b0;
         sticky_overflow <= 1'b0;
         done            <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (in_op == OP_LOAD) begin
                     acc             <= in_data;
                     flag_zero       <= (in_data == '0);
                     flag_carry      <= 1'b0;
                     flag_overflow   <= 1'b0;
                     sticky_overflow <= 1'b0;
                     done            <= 1'b1;
                  end else begin
                     adder_b        <= in_data;
                     adder_subtract <= (in_op != OP_ADD);
                     op_cmp         <= (in_op == OP_CMP);
                     count          <= CNT_W'(SETTLE_CYCLES - 1);
                  end
               end
            end
            SETTLE: begin
               if (count != '0) begin
                  count <= count - 1'b1;
               end
            end
            CAPTURE: begin
               // CMP only updates flags; the accumulator keeps its value.
               flag_zero       <= adder_zero;
               flag_carry      <= adder_carryout;
               flag_overflow   <= adder_overflow;
               sticky_overflow <= sticky_overflow | adder_overflow;
               if (!op_cmp) begin
                  acc <= adder_sum;
               end
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_accumulator.sv
// Bench for adder_accumulator: directed operations with hand-computed results,
// checked by a monitor against a queue of expected responses.
module tb_adder_accumulator;

   localparam int SETTLE = 4;
   localparam int W      = 36;
   localparam logic [1:0] ADD  = 2'b00;
   localparam logic [1:0] SUB  = 2'b01;
   localparam logic [1:0] LOAD = 2'b10;
   localparam logic [1:0] CMP  = 2'b11;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_data;
   logic [31:0] adder_a;
   logic [31:0] adder_b;
   logic        adder_subtract;
   logic [31:0] adder_sum;
   logic        adder_carryout;
   logic        adder_overflow;
   logic        adder_zero;
   logic [31:0] acc;
   logic        flag_zero;
   logic        flag_carry;
   logic        flag_overflow;
   logic        sticky_overflow;
   logic        done;

   int checks = 0;
   int errors = 0;
   int issued = 0;
   int accepts = 0;
   int cyc = 0;
   int last_acc = 0;
   int busy = 0;
   logic [31:0] held_b;
   logic        held_s;

   logic [W-1:0] exp_q[$];
   int           lat_q[$];

   adder_accumulator #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_data(in_data), .adder_a(adder_a), .adder_b(adder_b),
      .adder_subtract(adder_subtract), .adder_sum(adder_sum),
      .adder_carryout(adder_carryout), .adder_overflow(adder_overflow),
      .adder_zero(adder_zero), .acc(acc), .flag_zero(flag_zero),
      .flag_carry(flag_carry), .flag_overflow(flag_overflow),
      .sticky_overflow(sticky_overflow), .done(done)
   );

   // Stand-in for the external 32-bit ripple adder
   logic [32:0] add_r;
   logic [31:0] add_bb;
   always_comb begin
      add_bb         = adder_subtract ? ~adder_b : adder_b;
      add_r          = {1'b0, adder_a} + {1'b0, add_bb} + {32'd0, adder_subtract};
      adder_sum      = add_r[31:0];
      adder_carryout = add_r[32];
      adder_overflow = (adder_a[31] == add_bb[31]) && (add_r[31] != adder_a[31]);
      adder_zero     = (add_r[31:0] == 32'd0);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] pack(input logic [31:0] a, input logic z,
                                         input logic c, input logic o, input logic s);
      return {s, o, c, z, a};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Inputs change 2 time units after a rising edge; accept happens at the next
   // edge when in_ready was high during the preceding cycle.
   task automatic run(input logic [1:0] op, input logic [31:0] data, input logic [31:0] eacc,
                      input logic z, input logic c, input logic o, input logic s, input logic hold);
      logic got;
      int   n;
      in_valid = 1'b1;
      in_op    = op;
      in_data  = data;
      exp_q.push_back(pack(eacc, z, c, o, s));
      lat_q.push_back((op == LOAD) ? 1 : SETTLE + 2);
      issued++;
      n = 0;
      got = 1'b0;
      while (!got && n < 100) begin
         got = in_ready;
         @(posedge clk);
         #2;
         n++;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: op %0d not accepted within %0d cycles", op, n);
      end
      if (!hold) in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [W-1:0] e;
      int           l;
      cyc++;
      if (!rst_n) begin
         busy = 0;
         if (done) check("done_in_reset", {35'd0, done}, '0);
      end else begin
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: got done=1 expected no pending op at cycle %0d", cyc);
            end else begin
               e = exp_q.pop_front();
               l = lat_q.pop_front();
               check("result", {sticky_overflow, flag_overflow, flag_carry, flag_zero, acc}, e);
               check("latency", W'(cyc - last_acc), W'(l));
            end
         end
         if (!in_ready) begin
            if (busy > 0) check("settle_hold", {3'd0, held_s, adder_b}, {3'd0, adder_subtract, held_b});
            held_b = adder_b;
            held_s = adder_subtract;
            busy++;
         end else begin
            if (busy > 0) check("busy_len", W'(busy), W'(SETTLE + 1));
            busy = 0;
         end
         if (in_valid && in_ready) begin
            last_acc = cyc;
            accepts++;
         end
      end
   end

   initial begin
      int n;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_op    = 2'b00;
      in_data  = 32'd0;
      repeat (3) @(posedge clk);
      #2;
      check("reset_acc_flags", {sticky_overflow, flag_overflow, flag_carry, flag_zero, acc}, '0);
      check("reset_b_sub_done", {2'd0, done, adder_subtract, adder_b}, '0);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      check("ready_after_reset", {35'd0, in_ready}, W'(1));

      run(LOAD, 32'd5,          32'd5,          0, 0, 0, 0, 0);
      run(ADD,  32'd7,          32'd12,         0, 0, 0, 0, 0);
      run(LOAD, 32'd3,          32'd3,          0, 0, 0, 0, 0);
      run(SUB,  32'd5,          32'hFFFFFFFE,   0, 0, 0, 0, 0);
      run(LOAD, 32'd5,          32'd5,          0, 0, 0, 0, 0);
      run(SUB,  32'd3,          32'd2,          0, 1, 0, 0, 0);
      run(LOAD, 32'h7FFFFFFF,   32'h7FFFFFFF,   0, 0, 0, 0, 0);
      run(ADD,  32'd1,          32'h80000000,   0, 0, 1, 1, 0);
      run(ADD,  32'd1,          32'h80000001,   0, 0, 0, 1, 0);
      run(LOAD, 32'd0,          32'd0,          1, 0, 0, 0, 0);
      run(LOAD, 32'd12,         32'd12,         0, 0, 0, 0, 0);
      run(CMP,  32'd12,         32'd12,         1, 1, 0, 0, 0);
      run(CMP,  32'd13,         32'd12,         0, 0, 0, 0, 0);
      run(LOAD, 32'd0,          32'd0,          1, 0, 0, 0, 0);
      run(ADD,  32'd1,          32'd1,          0, 0, 0, 0, 1);
      run(ADD,  32'd1,          32'd2,          0, 0, 0, 0, 1);
      run(ADD,  32'd1,          32'd3,          0, 0, 0, 0, 0);
      run(LOAD, 32'hFFFFFFFF,   32'hFFFFFFFF,   0, 0, 0, 0, 0);
      run(ADD,  32'd1,          32'd0,          1, 1, 0, 0, 0);
      run(LOAD, 32'h80000000,   32'h80000000,   0, 0, 0, 0, 0);
      run(SUB,  32'd1,          32'h7FFFFFFF,   0, 1, 1, 1, 0);
      run(CMP,  32'h7FFFFFFF,   32'h7FFFFFFF,   1, 1, 0, 1, 0);

      // Abort an ADD mid-settle with an asynchronous reset: no capture, no done.
      run(LOAD, 32'd5,          32'd5,          0, 0, 0, 0, 0);
      in_valid = 1'b1;
      in_op    = ADD;
      in_data  = 32'd7;
      issued++;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset_acc_flags", {sticky_overflow, flag_overflow, flag_carry, flag_zero, acc}, '0);
      check("async_reset_done", {35'd0, done}, '0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      check("ready_after_abort", {34'd0, done, in_ready}, W'(1));
      run(LOAD, 32'd9,          32'd9,          0, 0, 0, 0, 0);

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      check("pending_responses", W'(exp_q.size()), '0);
      check("accept_count", W'(accepts), W'(issued));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_accumulator.md
Name: adder_accumulator

Overview:
Sequential accumulator stage wrapped around the 32-bit ripple add/subtract datapath. It accepts a stream of operations over a valid/ready handshake and drives the adder's a/b/subtract inputs from registers. It holds those inputs stable for a programmable settle window that covers ripple and zero-detect gate delay, then captures sum and flags into the accumulator. The external full 32-bit adder is instantiated beside this block at the next level up.

Parameters:
SETTLE_CYCLES, 4, clock cycles adder inputs are held before capture; legal range 1..255
CNT_W, 8, settle counter width; must hold SETTLE_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept an operation this cycle
in_op  input  2  00 ADD, 01 SUB, 10 LOAD, 11 CMP
in_data  input  32  operand
adder_a  output  32  to adder a; always equals acc
adder_b  output  32  to adder b; registered operand
adder_subtract  output  1  to adder subtract; registered
adder_sum  input  32  from adder sum
adder_carryout  input  1  from adder carryout
adder_overflow  input  1  from adder overflow
adder_zero  input  1  from adder zero
acc  output  32  accumulator value
flag_zero  output  1  result of last completed op was zero
flag_carry  output  1  adder carryout of last ADD/SUB/CMP
flag_overflow  output  1  adder overflow of last ADD/SUB/CMP
sticky_overflow  output  1  OR of overflows since last LOAD or reset
done  output  1  one-cycle pulse: operation completed, flags valid

Behaviour:
- Reset (rst_n low, asynchronous, any state): state IDLE; acc, adder_b, adder_subtract, all flags, counter = 0; done = 0. Any in-flight operation is aborted with no capture. in_ready = 1 from the first cycle after release.
- Accept occurs on a rising edge with in_valid && in_ready. in_ready = 1 only in IDLE. in_data and in_op are sampled only at accept.
- States: IDLE, SETTLE, CAPTURE.
- IDLE + accept LOAD:
  - acc <= in_data; flag_zero <= (in_data == 0); flag_carry, flag_overflow, sticky_overflow <= 0.
  - done = 1 in the next cycle. State stays IDLE, so back-to-back LOADs run at 1/cycle.
- IDLE + accept ADD/SUB/CMP:
  - adder_b <= in_data; adder_subtract <= in_op != ADD (SUB and CMP subtract); counter <= SETTLE_CYCLES-1.
  - Go to SETTLE.
- SETTLE:
  - adder_a/b/subtract are held constant.
  - If counter == 0, go to CAPTURE; otherwise decrement.
  - Adder inputs are therefore stable for exactly SETTLE_CYCLES cycles before capture.
- CAPTURE (one cycle; capture on the exiting edge):
  - flag_zero <= adder_zero; flag_carry <= adder_carryout; flag_overflow <= adder_overflow.
  - sticky_overflow <= sticky_overflow | adder_overflow.
  - ADD/SUB: acc <= adder_sum. CMP: acc unchanged.
  - Return to IDLE; done = 1 in the following cycle, which coincides with in_ready = 1.
- Latency: accept to done is SETTLE_CYCLES+2 cycles for ADD/SUB/CMP and 1 cycle for LOAD. Throughput is one arithmetic op per SETTLE_CYCLES+2 cycles.
- Flag semantics:
  - Carry follows the adder: for SUB, carry = 1 means no borrow (a >= b unsigned).
  - Overflow is two's-complement signed overflow.
- in_valid while in_ready = 0 is ignored. The requester must hold it; no request is queued or dropped silently beyond that.
- done never asserts without a preceding accept. Flags and acc change only at LOAD accept or CAPTURE.
- Wrap-around: results are modulo 2^32; no saturation.

Test Plan:
- LOAD 5, then ADD 7 (SETTLE_CYCLES=4) -> acc=12, zero=0, carry=0, ovf=0; done exactly 6 cycles after the ADD accept; in_ready low for 5 cycles.
- LOAD 3, then SUB 5 -> acc=0xFFFFFFFE, carry=0, ovf=0; then LOAD 5, SUB 3 -> acc=2, carry=1.
- LOAD 0x7FFFFFFF, ADD 1 -> acc=0x80000000, ovf=1, sticky=1; then ADD 1 -> ovf=0, sticky stays 1; then LOAD 0 -> sticky=0, zero=1.
- acc=12, CMP 12 -> zero=1, carry=1, acc remains 12; CMP 13 -> zero=0, carry=0.
- Hold in_valid high continuously with ADD 1 from acc=0 for 3 ops -> exactly 3 accepts 6 cycles apart; acc=3; adder_b/subtract stable throughout each SETTLE.
- Assert rst_n low mid-SETTLE -> acc and flags become 0 immediately (asynchronous); no done pulse; after release, in_ready=1 and the next LOAD 9 gives acc=9.
